// File: rtl/store_merge_ctrl_if.sv
// Store port bundle: pipeline store request side plus the word-wide data memory side.
// master = pipeline/memory environment, slave = store_merge_ctrl.
interface store_merge_ctrl_if;
    logic        st_req;
    logic        half_word_t;
    logic        byte_t;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        stall;
    logic        st_done;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output st_req, half_word_t, byte_t, st_addr, st_data, mem_rdata,
        input  stall, st_done, mem_addr, mem_rd, mem_wr, mem_wdata
    );

    modport slave (
        input  st_req, half_word_t, byte_t, st_addr, st_data, mem_rdata,
        output stall, st_done, mem_addr, mem_rd, mem_wr, mem_wdata
    );
endinterface

// File: rtl/store_merge_ctrl.sv
// Word/halfword store sequencer for a byte-enable-less word memory (RMW for partial stores).
// Optional byte stores (SB) are enabled by defining BYTE_STORE_EN.
module store_merge_ctrl (
    input  logic               clk,
    input  logic               rst,
    store_merge_ctrl_if.slave  bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned HALF_W = 16;
`ifdef BYTE_STORE_EN
    localparam int unsigned ADDR_LSB = 0;
`else
    localparam int unsigned ADDR_LSB = 1;
`endif

    typedef enum logic [1:0] {IDLE, RD, MRG, WR} state_t;

    state_t                     state;
    logic [ADDR_W-1:ADDR_LSB]   addr_q;
    logic [HALF_W-1:0]          data_q;
    logic [DATA_W-1:0]          wdata_q;
    logic                       mem_rd_q;
    logic                       mem_wr_q;
    logic                       st_done_q;
    logic                       is_rmw_c;
    logic [DATA_W-1:0]          merged_c;
`ifdef BYTE_STORE_EN
    logic                       byte_q;
`endif

    // Partial stores need the old word; full-word stores go straight to write.
`ifdef BYTE_STORE_EN
    assign is_rmw_c = bus.byte_t | bus.half_word_t;
`else
    assign is_rmw_c = bus.half_word_t;
`endif

    // Overlay the stored lane onto the word read back from memory.
    always_comb begin
        merged_c = bus.mem_rdata;
`ifdef BYTE_STORE_EN
        if (byte_q)
            merged_c[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
        else
`endif
        if (addr_q[1])
            merged_c[DATA_W-1:HALF_W] = data_q;
        else
            merged_c[HALF_W-1:0] = data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            wdata_q   <= '0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            st_done_q <= 1'b0;
`ifdef BYTE_STORE_EN
            byte_q    <= 1'b0;
`endif
        end else begin
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            st_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.st_req) begin
                        addr_q <= bus.st_addr[ADDR_W-1:ADDR_LSB];
                        data_q <= bus.st_data[HALF_W-1:0];
`ifdef BYTE_STORE_EN
                        byte_q <= bus.byte_t;
`endif
                        if (is_rmw_c) begin
                            state    <= RD;
                            mem_rd_q <= 1'b1;
                        end else begin
                            state     <= WR;
                            wdata_q   <= bus.st_data;
                            mem_wr_q  <= 1'b1;
                            st_done_q <= 1'b1;
                        end
                    end
                end
                RD: state <= MRG;
                MRG: begin
                    wdata_q   <= merged_c;
                    mem_wr_q  <= 1'b1;
                    st_done_q <= 1'b1;
                    state     <= WR;
                end
                WR:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Memory side is driven purely from registers; stall is the only combinational output.
    assign bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.st_done   = st_done_q;
    assign bus.stall     = bus.st_req & ~st_done_q;
endmodule

// File: tb/tb_store_merge_ctrl.sv
// Self-checking bench for store_merge_ctrl: vector table of single stores plus reset,
// flush and back-to-back sequences against a small synchronous word memory model.
module tb_store_merge_ctrl;
    logic clk;
    logic rst;

    store_merge_ctrl_if bus ();

    store_merge_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        string       name;
        logic        half;
        logic        byt;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] mem;
        logic [31:0] exp_w;
        int          lat;
    } vec_t;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] mem [256];
    logic        pre_en;
    logic [7:0]  pre_idx;
    logic [31:0] pre_val;
    int          wr_count;
    int          rd_count;
    logic        overlap;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous word memory: read data valid the cycle after mem_rd.
    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_val;
        if (bus.mem_rd) begin
            bus.mem_rdata <= mem[bus.mem_addr[9:2]];
            rd_count      <= rd_count + 1;
        end
        if (bus.mem_wr) begin
            mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
            wr_count               <= wr_count + 1;
        end
        if (bus.mem_rd && bus.mem_wr) overlap <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] val);
        pre_en  = 1'b1;
        pre_idx = addr[9:2];
        pre_val = val;
        @(posedge clk); #1;
        pre_en  = 1'b0;
    endtask

    // Issue one store, scramble operands after acceptance, check timing and written word.
    task automatic run_vec(input vec_t v, input bit do_preload);
        int   cyc;
        int   wr0;
        int   rd0;
        logic done_seen;
        if (do_preload) preload(v.addr, v.mem);
        wr0 = wr_count;
        rd0 = rd_count;
        bus.st_req      = 1'b1;
        bus.half_word_t = v.half;
        bus.byte_t      = v.byt;
        bus.st_addr     = v.addr;
        bus.st_data     = v.data;
        #1;
        check({v.name, " stall_accept"}, 32'(bus.stall), 32'd1);
        cyc       = 0;
        done_seen = 1'b0;
        while (!done_seen && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.st_done) begin
                done_seen = 1'b1;
            end else begin
                check({v.name, " stall_busy"}, 32'(bus.stall), 32'd1);
                bus.st_data     = ~v.data;
                bus.st_addr     = v.addr ^ 32'h0000_0046;
                bus.half_word_t = ~v.half;
                bus.byte_t      = ~v.byt;
            end
        end
        check({v.name, " st_done"},   32'(bus.st_done), 32'd1);
        check({v.name, " latency"},   32'(cyc), 32'(v.lat));
        check({v.name, " mem_wr"},    32'(bus.mem_wr), 32'd1);
        check({v.name, " mem_rd_wr"}, 32'(bus.mem_rd), 32'd0);
        check({v.name, " stall_done"}, 32'(bus.stall), 32'd0);
        check({v.name, " mem_addr"},  bus.mem_addr, {v.addr[31:2], 2'b00});
        check({v.name, " mem_wdata"}, bus.mem_wdata, v.exp_w);
        @(posedge clk); #1;
        bus.st_req = 1'b0;
        check({v.name, " wr_once"},   32'(wr_count - wr0), 32'd1);
        check({v.name, " rd_count"},  32'(rd_count - rd0), (v.lat == 3) ? 32'd1 : 32'd0);
        check({v.name, " mem_word"},  mem[v.addr[9:2]], v.exp_w);
        check({v.name, " idle_wr"},   32'(bus.mem_wr), 32'd0);
    endtask

    initial begin
        vec_t vecs [7];
        vec_t sw_b2b;
        vec_t sh_b2b;
        int   cyc;
        int   wr0;

        vecs[0] = '{"sw_104",   1'b0, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1};
        vecs[1] = '{"sh_202",   1'b1, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'h5566_7788, 32'hABCD_7788, 3};
        vecs[2] = '{"sh_200",   1'b1, 1'b0, 32'h0000_0200, 32'h1234_ABCD, 32'h5566_7788, 32'h5566_ABCD, 3};
        vecs[3] = '{"sh_201",   1'b1, 1'b0, 32'h0000_0201, 32'h1234_ABCD, 32'h5566_7788, 32'h5566_ABCD, 3};
        vecs[4] = '{"sw_107",   1'b0, 1'b0, 32'h0000_0107, 32'h0BAD_F00D, 32'hFFFF_FFFF, 32'h0BAD_F00D, 1};
`ifdef BYTE_STORE_EN
        vecs[5] = '{"sb_303",   1'b0, 1'b1, 32'h0000_0303, 32'h0000_00AA, 32'h1122_3344, 32'hAA22_3344, 3};
        vecs[6] = '{"sb_302",   1'b1, 1'b1, 32'h0000_0302, 32'h0000_BEEF, 32'h1122_3344, 32'h11EF_3344, 3};
`else
        vecs[5] = '{"sb_303",   1'b0, 1'b1, 32'h0000_0303, 32'h0000_00AA, 32'h1122_3344, 32'h0000_00AA, 1};
        vecs[6] = '{"sb_302",   1'b1, 1'b1, 32'h0000_0302, 32'h0000_BEEF, 32'h1122_3344, 32'hBEEF_3344, 3};
`endif
        sw_b2b = '{"b2b_sw", 1'b0, 1'b0, 32'h0000_0380, 32'hA5A5_5A5A, 32'h0000_0000, 32'hA5A5_5A5A, 1};
        sh_b2b = '{"b2b_sh", 1'b1, 1'b0, 32'h0000_03C2, 32'hFFFF_2468, 32'h9999_1111, 32'h2468_1111, 3};

        rst             = 1'b1;
        pre_en          = 1'b0;
        pre_idx         = '0;
        pre_val         = '0;
        wr_count        = 0;
        rd_count        = 0;
        overlap         = 1'b0;
        bus.st_req      = 1'b0;
        bus.half_word_t = 1'b0;
        bus.byte_t      = 1'b0;
        bus.st_addr     = '0;
        bus.st_data     = '0;
        #1;
        check("rst mem_rd",    32'(bus.mem_rd), 32'd0);
        check("rst mem_wr",    32'(bus.mem_wr), 32'd0);
        check("rst st_done",   32'(bus.st_done), 32'd0);
        check("rst mem_addr",  bus.mem_addr, 32'd0);
        check("rst mem_wdata", bus.mem_wdata, 32'd0);
        bus.st_req = 1'b1;
        #1;
        check("rst stall_follows_req", 32'(bus.stall), 32'd1);
        bus.st_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], 1'b1);

        // Back-to-back: SH request presented in the cycle right after the SW write.
        preload(sh_b2b.addr, sh_b2b.mem);
        run_vec(sw_b2b, 1'b1);
        run_vec(sh_b2b, 1'b0);

        // Flush: st_req dropped after acceptance, write still completes.
        preload(32'h0000_0240, 32'hCAFE_F00D);
        wr0             = wr_count;
        bus.st_req      = 1'b1;
        bus.half_word_t = 1'b1;
        bus.byte_t      = 1'b0;
        bus.st_addr     = 32'h0000_0242;
        bus.st_data     = 32'h0000_1357;
        @(posedge clk); #1;
        check("flush mem_rd", 32'(bus.mem_rd), 32'd1);
        bus.st_req = 1'b0;
        cyc = 1;
        while (!bus.st_done && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("flush latency",   32'(cyc), 32'd3);
        check("flush mem_wr",    32'(bus.mem_wr), 32'd1);
        check("flush mem_wdata", bus.mem_wdata, 32'h1357_F00D);
        check("flush stall",     32'(bus.stall), 32'd0);
        @(posedge clk); #1;
        check("flush wr_once",   32'(wr_count - wr0), 32'd1);

        // Reset while the RD of a halfword store is in flight: the write must never appear.
        preload(32'h0000_0200, 32'h5566_7788);
        bus.st_req      = 1'b1;
        bus.half_word_t = 1'b1;
        bus.st_addr     = 32'h0000_0202;
        bus.st_data     = 32'h1234_ABCD;
        @(posedge clk); #1;
        check("midrd mem_rd_before", 32'(bus.mem_rd), 32'd1);
        rst = 1'b1;
        #1;
        wr0 = wr_count;
        check("midrd mem_rd",   32'(bus.mem_rd), 32'd0);
        check("midrd mem_wr",   32'(bus.mem_wr), 32'd0);
        check("midrd mem_addr", bus.mem_addr, 32'd0);
        check("midrd st_done",  32'(bus.st_done), 32'd0);
        @(posedge clk); #1;
        rst        = 1'b0;
        bus.st_req = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrd no_write", 32'(wr_count - wr0), 32'd0);
        check("midrd mem_word", mem[8'h80], 32'h5566_7788);
        check("midrd idle_rd",  32'(bus.mem_rd), 32'd0);

        check("no_rd_wr_overlap", 32'(overlap), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
